// File: rtl/bp_mmio_arbiter_pkg.sv
// Purpose: shared target indices, FSM state type and platform address map for the uncached MMIO path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_mmio_arbiter_pkg;

  // Device-side target slots; bit positions in dev_v_o / dev_ready_i / dev_resp_v_i
  localparam int unsigned mmio_tgt_num   = 5;
  localparam int unsigned mmio_tgt_host  = 0;
  localparam int unsigned mmio_tgt_cfg   = 1;
  localparam int unsigned mmio_tgt_clint = 2;
  localparam int unsigned mmio_tgt_cache = 3;
  localparam int unsigned mmio_tgt_dram  = 4;

  // Platform map; device bases live in the low 2GB, one 1MB window per device nibble
  localparam logic [63:0] host_dev_base_addr  = 64'h0000_0000_0010_0000;
  localparam logic [63:0] cfg_dev_base_addr   = 64'h0000_0000_0020_0000;
  localparam logic [63:0] clint_dev_base_addr = 64'h0000_0000_0030_0000;
  localparam logic [63:0] cache_dev_base_addr = 64'h0000_0000_0040_0000;
  localparam logic [63:0] dram_base_addr      = 64'h0000_0000_8000_0000;
  localparam logic [63:0] coproc_base_addr    = 64'h0000_0010_0000_0000;

  typedef enum logic [1:0] {
    e_mmio_idle,
    e_mmio_send,
    e_mmio_wait,
    e_mmio_resp
  } mmio_state_e;

endpackage

// File: rtl/bp_mmio_addr_decode.sv
// Purpose: maps a physical address to {mapped, one-hot target} for the uncached MMIO targets.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake on this block.
module bp_mmio_addr_decode
  import bp_mmio_arbiter_pkg::*;
#(
  parameter int paddr_width_p = 40
) (
  input  logic [paddr_width_p-1:0] paddr_i,
  output logic                     mapped_o,
  output logic [mmio_tgt_num-1:0]  tgt_o
);

  logic [63:0] addr_ext;
  assign addr_ext = {{(64-paddr_width_p){1'b0}}, paddr_i};

  // DRAM window first, then the device nibble in the low 16MB; anything else stays unmapped
  always_comb begin
    tgt_o = '0;
    if (addr_ext >= dram_base_addr && addr_ext < coproc_base_addr) begin
      tgt_o[mmio_tgt_dram] = 1'b1;
    end else if (addr_ext[63:24] == '0) begin
      case (addr_ext[23:20])
        host_dev_base_addr[23:20]:  tgt_o[mmio_tgt_host]  = 1'b1;
        cfg_dev_base_addr[23:20]:   tgt_o[mmio_tgt_cfg]   = 1'b1;
        clint_dev_base_addr[23:20]: tgt_o[mmio_tgt_clint] = 1'b1;
        cache_dev_base_addr[23:20]: tgt_o[mmio_tgt_cache] = 1'b1;
        default:                    tgt_o = '0;
      endcase
    end
  end

  assign mapped_o = |tgt_o;

endmodule

// File: rtl/bp_mmio_arbiter.sv
// Purpose: round-robin share of the uncached MMIO path, one transaction in flight, with decode and timeout.
// Latency: mapped accept c0, dev_v_o c1, resp_v_o c3 at best; unmapped resp_v_o c1.
// Backpressure: req_ready_o only in IDLE; dev_v_o held until dev_ready_i or timeout; resp_v_o held until resp_ready_i.
module bp_mmio_arbiter
  import bp_mmio_arbiter_pkg::*;
#(
  parameter int num_req_p     = 2,
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64,
  parameter int timeout_p     = 1024
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_req_p-1:0]                req_v_i,
  output logic [num_req_p-1:0]                req_ready_o,
  input  logic [num_req_p*paddr_width_p-1:0]  req_addr_i,
  input  logic [num_req_p-1:0]                req_we_i,
  input  logic [num_req_p*2-1:0]              req_size_i,
  input  logic [num_req_p*data_width_p-1:0]   req_data_i,
  output logic [mmio_tgt_num-1:0]             dev_v_o,
  input  logic [mmio_tgt_num-1:0]             dev_ready_i,
  output logic [paddr_width_p-1:0]            dev_addr_o,
  output logic                                dev_we_o,
  output logic [1:0]                          dev_size_o,
  output logic [data_width_p-1:0]             dev_data_o,
  input  logic [mmio_tgt_num-1:0]             dev_resp_v_i,
  input  logic [mmio_tgt_num*data_width_p-1:0] dev_resp_data_i,
  output logic [num_req_p-1:0]                resp_v_o,
  output logic [data_width_p-1:0]             resp_data_o,
  output logic                                resp_err_o,
  input  logic [num_req_p-1:0]                resp_ready_i
);

  localparam int gw = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cw = $clog2(timeout_p) + 1;

  mmio_state_e             state;
  logic [gw-1:0]           last_grant;
  logic [gw-1:0]           grant_r;
  logic [mmio_tgt_num-1:0] tgt_r;
  logic [cw-1:0]           cnt;

  logic                     found;
  logic [gw-1:0]            gidx;
  logic [num_req_p-1:0]     gidx_oh;
  logic [num_req_p-1:0]     grant_oh;
  logic [paddr_width_p-1:0] sel_addr;
  logic                     dec_mapped;
  logic [mmio_tgt_num-1:0]  dec_tgt;
  logic [data_width_p-1:0]  resp_sel_data;
  logic                     timeout_hit;
  logic                     dev_hs;
  logic                     resp_hit;

  // Round-robin: first requester at or above last_grant+1, wrapping
  always_comb begin
    found = 1'b0;
    gidx  = last_grant;
    for (int i = 1; i <= num_req_p; i++) begin
      int j;
      j = int'(last_grant) + i;
      if (j >= num_req_p) j = j - num_req_p;
      if (!found && req_v_i[j]) begin
        found = 1'b1;
        gidx  = gw'(j);
      end
    end
  end

  // One-hot forms of the candidate grant and the latched grant
  always_comb begin
    gidx_oh           = '0;
    gidx_oh[gidx]     = 1'b1;
    grant_oh          = '0;
    grant_oh[grant_r] = 1'b1;
  end

  // Accept is the only combinational output; held low while reset is asserted
  always_comb begin
    req_ready_o = '0;
    if (reset_n_i && state == e_mmio_idle && found) req_ready_o = gidx_oh;
  end

  assign sel_addr = req_addr_i[gidx*paddr_width_p +: paddr_width_p];

  bp_mmio_addr_decode #(
    .paddr_width_p(paddr_width_p)
  ) u_decode (
    .paddr_i (sel_addr),
    .mapped_o(dec_mapped),
    .tgt_o   (dec_tgt)
  );

  // Pick the response data lane of the selected target
  always_comb begin
    resp_sel_data = '0;
    for (int t = 0; t < mmio_tgt_num; t++) begin
      if (tgt_r[t]) resp_sel_data = dev_resp_data_i[t*data_width_p +: data_width_p];
    end
  end

  assign timeout_hit = (cnt == cw'(timeout_p - 1));
  assign dev_hs      = |(dev_v_o & dev_ready_i);
  assign resp_hit    = |(tgt_r & dev_resp_v_i);

  // Transaction FSM; all device/response outputs are registered here
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= e_mmio_idle;
      last_grant  <= gw'(num_req_p - 1);
      grant_r     <= '0;
      tgt_r       <= '0;
      cnt         <= '0;
      dev_v_o     <= '0;
      dev_addr_o  <= '0;
      dev_we_o    <= 1'b0;
      dev_size_o  <= '0;
      dev_data_o  <= '0;
      resp_v_o    <= '0;
      resp_data_o <= '0;
      resp_err_o  <= 1'b0;
    end else begin
      case (state)
        e_mmio_idle: begin
          if (found) begin
            grant_r    <= gidx;
            tgt_r      <= dec_tgt;
            cnt        <= '0;
            dev_addr_o <= sel_addr;
            dev_we_o   <= req_we_i[gidx];
            dev_size_o <= req_size_i[gidx*2 +: 2];
            dev_data_o <= req_data_i[gidx*data_width_p +: data_width_p];
            if (dec_mapped) begin
              dev_v_o <= dec_tgt;
              state   <= e_mmio_send;
            end else begin
              resp_v_o    <= gidx_oh;
              resp_err_o  <= 1'b1;
              resp_data_o <= '0;
              state       <= e_mmio_resp;
            end
          end
        end
        e_mmio_send: begin
          cnt <= cnt + 1'b1;
          if (dev_hs) begin
            dev_v_o <= '0;
            state   <= e_mmio_wait;
          end else if (timeout_hit) begin
            dev_v_o     <= '0;
            resp_v_o    <= grant_oh;
            resp_err_o  <= 1'b1;
            resp_data_o <= '0;
            state       <= e_mmio_resp;
          end
        end
        e_mmio_wait: begin
          cnt <= cnt + 1'b1;
          if (resp_hit) begin
            resp_v_o    <= grant_oh;
            resp_err_o  <= 1'b0;
            resp_data_o <= resp_sel_data;
            state       <= e_mmio_resp;
          end else if (timeout_hit) begin
            resp_v_o    <= grant_oh;
            resp_err_o  <= 1'b1;
            resp_data_o <= '0;
            state       <= e_mmio_resp;
          end
        end
        e_mmio_resp: begin
          if (|(resp_v_o & resp_ready_i)) begin
            resp_v_o   <= '0;
            last_grant <= grant_r;
            state      <= e_mmio_idle;
          end
        end
        default: state <= e_mmio_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_mmio_arbiter.sv
// Purpose: directed self-checking bench for bp_mmio_arbiter (two requesters, short timeout).
// Latency: inputs driven 2 time units after each rising edge, outputs sampled in the same window.
// Backpressure: responses acked explicitly by each scenario.
module tb_bp_mmio_arbiter;

  localparam int NR = 2;
  localparam int AW = 40;
  localparam int DW = 64;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset_n_i = 1'b1;
  logic [NR-1:0]   req_v_i, req_ready_o, req_we_i, resp_v_o, resp_ready_i;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*2-1:0] req_size_i;
  logic [NR*DW-1:0] req_data_i;
  logic [4:0]      dev_v_o, dev_ready_i, dev_resp_v_i;
  logic [AW-1:0]   dev_addr_o;
  logic            dev_we_o;
  logic [1:0]      dev_size_o;
  logic [DW-1:0]   dev_data_o;
  logic [5*DW-1:0] dev_resp_data_i;
  logic [DW-1:0]   resp_data_o;
  logic            resp_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bp_mmio_arbiter #(
    .num_req_p(NR), .paddr_width_p(AW), .data_width_p(DW), .timeout_p(TO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_data_i(req_data_i),
    .dev_v_o(dev_v_o), .dev_ready_i(dev_ready_i), .dev_addr_o(dev_addr_o),
    .dev_we_o(dev_we_o), .dev_size_o(dev_size_o), .dev_data_o(dev_data_o),
    .dev_resp_v_i(dev_resp_v_i), .dev_resp_data_i(dev_resp_data_i),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .resp_ready_i(resp_ready_i)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    req_v_i = '0; dev_ready_i = '0; dev_resp_v_i = '0; resp_ready_i = '0;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    clr();
    step(); step();
    reset_n_i = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    req_v_i = 2'b11;
    #3;
    total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL rst_req_ready got=%b exp=00", req_ready_o); end
    total++; if (dev_v_o !== 5'b0) begin bad++; $display("FAIL rst_dev_v got=%b exp=00000", dev_v_o); end
    total++; if (resp_v_o !== 2'b00) begin bad++; $display("FAIL rst_resp_v got=%b exp=00", resp_v_o); end
    total++; if (resp_err_o !== 1'b0) begin bad++; $display("FAIL rst_resp_err got=%b exp=0", resp_err_o); end
    total++; if (resp_data_o !== 64'h0) begin bad++; $display("FAIL rst_resp_data got=%h exp=0", resp_data_o); end
    total++; if ({dev_addr_o, dev_we_o, dev_size_o, dev_data_o} !== '0) begin bad++; $display("FAIL rst_dev_fields got=%h/%b/%h/%h exp=0", dev_addr_o, dev_we_o, dev_size_o, dev_data_o); end
    req_v_i = 2'b00;
    step(); step();
    reset_n_i = 1'b1;
    step();
  endtask

  task automatic test_clint_read();
    req_addr_i[0 +: AW] = 40'h00_0030_bff8;
    req_we_i = 2'b00;
    req_size_i[1:0] = 2'd3;
    req_v_i = 2'b01;
    #1;
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL clint_accept got=%b exp=01", req_ready_o); end
    step();
    req_v_i = 2'b00;
    total++; if (dev_v_o !== 5'b00100) begin bad++; $display("FAIL clint_dev_v got=%b exp=00100", dev_v_o); end
    total++; if (dev_addr_o !== 40'h00_0030_bff8) begin bad++; $display("FAIL clint_dev_addr got=%h exp=000030bff8", dev_addr_o); end
    total++; if (dev_size_o !== 2'd3 || dev_we_o !== 1'b0) begin bad++; $display("FAIL clint_dev_size_we got=%0d/%b exp=3/0", dev_size_o, dev_we_o); end
    dev_ready_i = 5'b00100;
    step();
    dev_ready_i = 5'b0;
    total++; if (dev_v_o !== 5'b0 || resp_v_o !== 2'b00) begin bad++; $display("FAIL clint_wait got=%b/%b exp=00000/00", dev_v_o, resp_v_o); end
    dev_resp_v_i = 5'b00100;
    dev_resp_data_i[2*DW +: DW] = 64'h1234;
    step();
    dev_resp_v_i = 5'b0;
    total++; if (resp_v_o !== 2'b01) begin bad++; $display("FAIL clint_resp_v got=%b exp=01", resp_v_o); end
    total++; if (resp_data_o !== 64'h1234) begin bad++; $display("FAIL clint_resp_data got=%h exp=1234", resp_data_o); end
    total++; if (resp_err_o !== 1'b0) begin bad++; $display("FAIL clint_resp_err got=%b exp=0", resp_err_o); end
    resp_ready_i = 2'b01;
    step();
    resp_ready_i = 2'b00;
    total++; if (resp_v_o !== 2'b00) begin bad++; $display("FAIL clint_resp_drop got=%b exp=00", resp_v_o); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  eoh;
    logic [63:0] edat;
    do_reset();
    req_addr_i[0 +: AW]  = 40'h00_8000_0000;
    req_addr_i[AW +: AW] = 40'h00_8000_0000;
    req_data_i[0 +: DW]  = 64'hA0;
    req_data_i[DW +: DW] = 64'hB1;
    req_we_i = 2'b10;
    req_v_i  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      eoh  = ((k & 1) == 0) ? 2'b01 : 2'b10;
      edat = ((k & 1) == 0) ? 64'hA0 : 64'hB1;
      #1;
      total++; if (req_ready_o !== eoh) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready_o, eoh); end
      step();
      total++; if (dev_v_o !== 5'b10000 || dev_data_o !== edat) begin bad++; $display("FAIL rr_dev%0d got=%b/%h exp=10000/%h", k, dev_v_o, dev_data_o, edat); end
      total++; if (dev_we_o !== eoh[1] || req_ready_o !== 2'b00) begin bad++; $display("FAIL rr_we_busy%0d got=%b/%b exp=%b/00", k, dev_we_o, req_ready_o, eoh[1]); end
      dev_ready_i = 5'b10000;
      step();
      dev_ready_i = 5'b0;
      dev_resp_v_i = 5'b10000;
      dev_resp_data_i[4*DW +: DW] = 64'h100 + 64'(k);
      step();
      dev_resp_v_i = 5'b0;
      total++; if (resp_v_o !== eoh || resp_data_o !== 64'h100 + 64'(k) || req_ready_o !== 2'b00) begin bad++; $display("FAIL rr_resp%0d got=%b/%h/%b exp=%b/%h/00", k, resp_v_o, resp_data_o, req_ready_o, eoh, 64'h100 + 64'(k)); end
      resp_ready_i = eoh;
      step();
      resp_ready_i = 2'b00;
    end
    req_v_i = 2'b00;
    req_we_i = 2'b00;
  endtask

  task automatic test_unmapped();
    req_addr_i[0 +: AW] = 40'h00_0050_0000;
    req_v_i = 2'b01;
    #1;
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL unm5_accept got=%b exp=01", req_ready_o); end
    step();
    req_v_i = 2'b00;
    total++; if (resp_v_o !== 2'b01 || resp_err_o !== 1'b1 || resp_data_o !== 64'h0) begin bad++; $display("FAIL unm5_resp got=%b/%b/%h exp=01/1/0", resp_v_o, resp_err_o, resp_data_o); end
    total++; if (dev_v_o !== 5'b0) begin bad++; $display("FAIL unm5_dev_v got=%b exp=00000", dev_v_o); end
    resp_ready_i = 2'b01;
    step();
    resp_ready_i = 2'b00;
    req_addr_i[AW +: AW] = 40'h10_0000_0000;
    req_v_i = 2'b10;
    #1;
    total++; if (req_ready_o !== 2'b10) begin bad++; $display("FAIL unmcp_accept got=%b exp=10", req_ready_o); end
    step();
    req_v_i = 2'b00;
    total++; if (resp_v_o !== 2'b10 || resp_err_o !== 1'b1 || resp_data_o !== 64'h0) begin bad++; $display("FAIL unmcp_resp got=%b/%b/%h exp=10/1/0", resp_v_o, resp_err_o, resp_data_o); end
    total++; if (dev_v_o !== 5'b0) begin bad++; $display("FAIL unmcp_dev_v got=%b exp=00000", dev_v_o); end
    resp_ready_i = 2'b10;
    step();
    resp_ready_i = 2'b00;
  endtask

  task automatic test_timeout();
    req_addr_i[0 +: AW] = 40'h00_0020_0000;
    req_v_i = 2'b01;
    #1;
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL to_accept got=%b exp=01", req_ready_o); end
    step();
    req_v_i = 2'b00;
    total++; if (dev_v_o !== 5'b00010) begin bad++; $display("FAIL to_send got=%b exp=00010", dev_v_o); end
    for (int k = 2; k <= 8; k++) begin
      step();
      total++; if (resp_v_o !== 2'b00 || dev_v_o !== 5'b00010) begin bad++; $display("FAIL to_hold_c%0d got=%b/%b exp=00/00010", k, resp_v_o, dev_v_o); end
    end
    step();
    total++; if (resp_v_o !== 2'b01 || resp_err_o !== 1'b1 || resp_data_o !== 64'h0) begin bad++; $display("FAIL to_resp got=%b/%b/%h exp=01/1/0", resp_v_o, resp_err_o, resp_data_o); end
    total++; if (dev_v_o !== 5'b0) begin bad++; $display("FAIL to_dev_drop got=%b exp=00000", dev_v_o); end
    dev_resp_v_i = 5'b00010;
    dev_resp_data_i[1*DW +: DW] = 64'hdead;
    step();
    total++; if (resp_v_o !== 2'b01 || resp_err_o !== 1'b1 || resp_data_o !== 64'h0) begin bad++; $display("FAIL to_late_resp got=%b/%b/%h exp=01/1/0", resp_v_o, resp_err_o, resp_data_o); end
    resp_ready_i = 2'b01;
    step();
    resp_ready_i = 2'b00;
    step();
    total++; if (resp_v_o !== 2'b00 || dev_v_o !== 5'b0) begin bad++; $display("FAIL to_late_idle got=%b/%b exp=00/00000", resp_v_o, dev_v_o); end
    dev_resp_v_i = 5'b0;
  endtask

  task automatic test_wrong_target();
    req_addr_i[AW +: AW] = 40'h00_9000_0000;
    req_v_i = 2'b10;
    #1;
    total++; if (req_ready_o !== 2'b10) begin bad++; $display("FAIL wt_accept got=%b exp=10", req_ready_o); end
    step();
    req_v_i = 2'b00;
    total++; if (dev_v_o !== 5'b10000) begin bad++; $display("FAIL wt_dev_v got=%b exp=10000", dev_v_o); end
    dev_ready_i = 5'b10000;
    step();
    dev_ready_i = 5'b0;
    dev_resp_v_i = 5'b00001;
    dev_resp_data_i[0 +: DW] = 64'hbad;
    step();
    total++; if (resp_v_o !== 2'b00) begin bad++; $display("FAIL wt_ignored got=%b exp=00", resp_v_o); end
    dev_resp_v_i = 5'b10000;
    dev_resp_data_i[4*DW +: DW] = 64'h5555;
    step();
    dev_resp_v_i = 5'b0;
    total++; if (resp_v_o !== 2'b10 || resp_data_o !== 64'h5555 || resp_err_o !== 1'b0) begin bad++; $display("FAIL wt_resp got=%b/%h/%b exp=10/5555/0", resp_v_o, resp_data_o, resp_err_o); end
    resp_ready_i = 2'b10;
    step();
    resp_ready_i = 2'b00;
  endtask

  task automatic test_reset_mid();
    req_addr_i[0 +: AW] = 40'h0;
    req_v_i = 2'b01;
    step();
    req_v_i = 2'b00;
    resp_ready_i = 2'b01;
    step();
    resp_ready_i = 2'b00;
    req_addr_i[AW +: AW] = 40'h00_8000_0000;
    req_v_i = 2'b10;
    #1;
    total++; if (req_ready_o !== 2'b10) begin bad++; $display("FAIL mr_accept got=%b exp=10", req_ready_o); end
    step();
    req_v_i = 2'b11;
    dev_ready_i = 5'b10000;
    step();
    dev_ready_i = 5'b0;
    #1;
    reset_n_i = 1'b0;
    #1;
    total++; if (dev_v_o !== 5'b0 || resp_v_o !== 2'b00 || req_ready_o !== 2'b00) begin bad++; $display("FAIL mr_valids got=%b/%b/%b exp=00000/00/00", dev_v_o, resp_v_o, req_ready_o); end
    total++; if (dev_addr_o !== 40'h0) begin bad++; $display("FAIL mr_dev_addr got=%h exp=0", dev_addr_o); end
    step(); step();
    reset_n_i = 1'b1;
    #1;
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL mr_first_grant got=%b exp=01", req_ready_o); end
    step();
    req_v_i = 2'b00;
  endtask

  initial begin
    clr();
    req_addr_i = '0; req_we_i = '0; req_size_i = '0; req_data_i = '0;
    dev_resp_data_i = '0;
    #1;
    test_reset();
    test_clint_read();
    test_round_robin();
    test_unmapped();
    test_timeout();
    test_wrong_target();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
